bin16_ascii_converter: RTL and testbench
========================================

// Module: bin16_ascii_converter
// PURPOSE
//  Sequential 16-bit binary to 5-digit decimal ASCII converter using shift-add-3 (double dabble).
//  Sits directly upstream of the memory-mapped I/O window and drives its read-only
//  double_dabble[5] bytes at 0x7FE0..0x7FE4, so the CPU reads a decimal string with no software divide.
//  Digit 0 is the ten-thousands digit (most significant); digit 4 is the units digit.
// PARAMETERS
//  AUTO_START  1      1: re-convert automatically whenever bin_in differs from the last converted value
//  ZERO_CHAR   8'h30  ASCII code added to each BCD digit ('0')
//  BLANK_CHAR  8'h20  code emitted for a blanked leading zero (' ')
// PORTS
//  clk          in   1      system clock; all state changes on the rising edge
//  reset_n      in   1      asynchronous, active-low reset
//  bin_in       in   16     unsigned value to convert
//  start        in   1      request one conversion (level, sampled in IDLE only)
//  blank_zeros  in   1      1: replace leading zero digits with BLANK_CHAR
//  busy         out  1      1 while a conversion is in progress
//  done         out  1      one-cycle pulse the cycle after double_dabble is updated
//  double_dabble out 8 x [5] ASCII digits, [0] = MSD .. [4] = LSD
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, busy=0, done=0, every double_dabble[i]=ZERO_CHAR,
//   last_value=16'h0000, shift and BCD registers cleared. Asserting reset mid-conversion aborts it; no partial result appears.
//  FSM states: IDLE -> SHIFT -> FORMAT -> IDLE.
//  IDLE: conversion is triggered when start=1, or when AUTO_START=1 and bin_in != last_value.
//   On the trigger edge: bin_in -> shift_reg, blank_zeros -> blank_lat, bin_in -> last_value,
//   bcd(20b)=0, cnt=0, go to SHIFT, busy=1.
//  SHIFT (exactly 16 cycles): each edge, every 4-bit BCD digit >=5 gets +3.
//   Then {bcd,shift_reg} <<= 1 (MSB first). cnt++.
//   Leave to FORMAT on the edge where cnt==15.
//   Because 65535 < 100000, the 20-bit BCD never overflows; no carry out of digit 0 exists.
//  FORMAT (1 cycle): double_dabble[i] = ZERO_CHAR + bcd digit i, written on this edge, all five
//   bytes updated atomically. If blank_lat=1, each leading digit that is 0 and precedes the first
//   nonzero digit becomes BLANK_CHAR. Digit 4 is never blanked, so value 0 -> "    0".
//   Next state IDLE, busy=0, done=1 for exactly one cycle.
//  Latency: trigger edge E0 -> outputs valid after edge E0+17, done high during the cycle after E0+17.
//   The earliest next trigger is edge E0+18 (back-to-back throughput is 18 cycles per conversion).
//  bin_in/blank_zeros changes while busy are ignored for the current conversion.
//   With AUTO_START=1, a changed bin_in is picked up on the first IDLE edge after completion.
//  start while busy is ignored, not queued. Holding start high in IDLE re-converts continuously.
//  Outputs hold their last value between conversions. No intermediate BCD value is ever visible on double_dabble.
//  Simultaneous start and AUTO trigger: a single conversion.
// TESTING
//  T1 reset_n low for 2 cycles -> busy=0, done=0, all bytes 8'h30. Release with bin_in=0, AUTO=1 -> no conversion.
//  T2 AUTO=1, bin_in=16'd65535 -> after 18 edges bytes = 36 35 35 33 35 ("65535"), done pulse of width 1.
//  T3 bin_in=16'd42, blank_zeros=1, start pulse -> "   42" (20 20 20 34 32). With blank_zeros=0 -> "00042".
//  T4 bin_in=0, blank_zeros=1, start -> "    0". bin_in=10000 -> "10000" (inner zeros not blanked).
//  T5 bin_in changed 1234->5678 at cycle 5 of a conversion -> result "01234", then an auto conversion to "05678".
//   Start pulses during busy produce no extra done.
//  T6 reset_n pulsed low at SHIFT cycle 8 of converting 9999 -> bytes return to "00000" immediately, busy=0.
//   No done pulse for the aborted conversion.
//  T7 randomized: 2000 random values vs reference model, checking every byte, latency and a single done per trigger.

Source files
------------

// File: rtl/bin16_ascii_converter.sv
// -----------------------------------------------------------------------------
// bin16_ascii_converter
//   Sequential 16-bit binary to 5-digit decimal ASCII converter using the
//   shift-add-3 (double dabble) algorithm. The five ASCII bytes feed a
//   read-only window so software reads a decimal string with no divide.
//   Digit 0 is the ten-thousands digit (MSD), digit 4 the units digit (LSD).
//
// Ports
//   clk            in   1     system clock, rising-edge active
//   reset_n        in   1     asynchronous active-low reset
//   bin_in         in   16    unsigned value to convert
//   start          in   1     conversion request (level, sampled in IDLE only)
//   blank_zeros    in   1     1: leading zero digits become BLANK_CHAR
//   busy           out  1     high while a conversion is in progress
//   done           out  1     one-cycle pulse after double_dabble updates
//   double_dabble  out  8x5   ASCII digits, [0] = MSD .. [4] = LSD
//   dbg_state_o    out  2     current FSM state (debug visibility)
//
// Handshake: a request is accepted only on an IDLE edge where start=1 or
// (AUTO_START=1 and bin_in differs from the last converted value); requests
// while busy are dropped, not queued. done pulses exactly once per accepted
// request, and double_dabble is stable whenever busy=0.
// -----------------------------------------------------------------------------
module bin16_ascii_converter #(
  parameter bit         AUTO_START = 1'b1,
  parameter logic [7:0] ZERO_CHAR  = 8'h30,
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] bin_in,
  input  logic        start,
  input  logic        blank_zeros,
  output logic        busy,
  output logic        done,
  output logic [7:0]  double_dabble [5],
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FORMAT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] shift_q, shift_d;
  logic [19:0] bcd_q,   bcd_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        blank_q, blank_d;
  logic [15:0] last_q,  last_d;
  logic        done_q,  done_d;
  logic [7:0]  dd_q [5];
  logic [7:0]  dd_d [5];

  logic        trigger;
  logic [19:0] bcd_adj;
  logic        lead;
  logic [3:0]  digit;

  assign trigger = start || (AUTO_START && (bin_in != last_q));

  // Add-3 correction applied to every BCD digit before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    last_d  = last_q;
    done_d  = 1'b0;
    dd_d    = dd_q;
    lead    = 1'b0;
    digit   = 4'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          shift_d = bin_in;
          blank_d = blank_zeros;
          last_d  = bin_in;
          bcd_d   = 20'd0;
          cnt_d   = 4'd0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // MSB of the binary shift register enters the BCD LSB.
        {bcd_d, shift_d} = {bcd_adj[18:0], shift_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = ST_FORMAT;
        end
      end

      ST_FORMAT: begin
        // Blanking stops at the first nonzero digit; the units digit always shows.
        lead = blank_q;
        for (int i = 0; i < 5; i++) begin
          digit = bcd_q[(4-i)*4 +: 4];
          if (lead && (digit == 4'd0) && (i < 4)) begin
            dd_d[i] = BLANK_CHAR;
          end else begin
            dd_d[i] = ZERO_CHAR + {4'd0, digit};
            lead    = 1'b0;
          end
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shift_q <= 16'd0;
      bcd_q   <= 20'd0;
      cnt_q   <= 4'd0;
      blank_q <= 1'b0;
      last_q  <= 16'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        dd_q[i] <= ZERO_CHAR;
      end
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      last_q  <= last_d;
      done_q  <= done_d;
      for (int i = 0; i < 5; i++) begin
        dd_q[i] <= dd_d[i];
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign double_dabble = dd_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_bin16_ascii_converter.sv
module tb_bin16_ascii_converter;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] bin_in;
  logic        start;
  logic        blank_zeros;
  logic        busy;
  logic        done;
  logic [7:0]  double_dabble [5];
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  bin16_ascii_converter #(
    .AUTO_START (1'b1),
    .ZERO_CHAR  (8'h30),
    .BLANK_CHAR (8'h20)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .bin_in        (bin_in),
    .start         (start),
    .blank_zeros   (blank_zeros),
    .busy          (busy),
    .done          (done),
    .double_dabble (double_dabble),
    .dbg_state_o   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [39:0] exp_q[$];

  function automatic logic [39:0] dd_now();
    return {double_dabble[0], double_dabble[1], double_dabble[2],
            double_dabble[3], double_dabble[4]};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division, then leading-zero blanking.
  function automatic logic [39:0] model(input int v, input bit blk);
    logic [39:0] r;
    int p;
    int d;
    bit lead;
    r = '0;
    p = 10000;
    lead = blk;
    for (int i = 0; i < 5; i++) begin
      d = (v / p) % 10;
      if (lead && d == 0 && i < 4) r[(4-i)*8 +: 8] = 8'h20;
      else begin
        r[(4-i)*8 +: 8] = 8'h30 + d[7:0];
        lead = 0;
      end
      p = p / 10;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 40'(busy), 40'd0);
  endtask

  // Start-triggered conversion; checks latency, hold, result and done width.
  task automatic run_conv(input logic [15:0] val, input logic blk, input string name);
    int n;
    bit got;
    bit hold_ok;
    logic [39:0] prev;
    logic [39:0] exp;
    wait_idle();
    @(negedge clk);
    bin_in = val;
    blank_zeros = blk;
    start = 1'b1;
    prev = dd_now();
    exp_q.push_back(model(int'(val), blk));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    got = 0;
    hold_ok = 1;
    while (n < 40 && !got) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) got = 1;
      else if (dd_now() !== prev) hold_ok = 0;
    end
    exp = exp_q.pop_front();
    check({name, "_latency"}, 40'(n), 40'd17);
    check({name, "_hold"}, 40'(hold_ok), 40'd1);
    check({name, "_value"}, dd_now(), exp);
    @(posedge clk);
    @(negedge clk);
    check({name, "_done_width"}, 40'(done), 40'd0);
  endtask

  typedef struct {
    logic [15:0] val;
    logic        blk;
    logic [39:0] exp;
  } vec_t;
  vec_t vecs[9];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int dones;
    int done_at[2];
    logic [39:0] done_val[2];
    bit bad;

    vecs[0] = '{16'd42,    1'b1, "   42"};
    vecs[1] = '{16'd42,    1'b0, "00042"};
    vecs[2] = '{16'd0,     1'b1, "    0"};
    vecs[3] = '{16'd10000, 1'b1, "10000"};
    vecs[4] = '{16'd0,     1'b0, "00000"};
    vecs[5] = '{16'd7,     1'b1, "    7"};
    vecs[6] = '{16'd100,   1'b1, "  100"};
    vecs[7] = '{16'd65535, 1'b1, "65535"};
    vecs[8] = '{16'd1001,  1'b1, " 1001"};

    // T1: reset
    reset_n = 1'b0;
    bin_in = 16'd0;
    start = 1'b0;
    blank_zeros = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 40'(busy), 40'd0);
    check("rst_done", 40'(done), 40'd0);
    check("rst_bytes", dd_now(), "00000");
    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) bad = 1;
    end
    check("rst_no_auto", 40'(bad), 40'd0);

    // T2: auto-triggered 65535
    @(negedge clk);
    bin_in = 16'd65535;
    n = 0;
    dones = 0;
    while (n < 40 && dones == 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) dones++;
    end
    check("auto_latency", 40'(n), 40'd18);
    check("auto_value", dd_now(), "65535");
    @(negedge clk);
    check("auto_done_width", 40'(done), 40'd0);

    // T3/T4: table vectors
    foreach (vecs[i]) run_conv(vecs[i].val, vecs[i].blk, $sformatf("vec%0d", i));

    // T5: input change and start while busy
    wait_idle();
    @(negedge clk);
    bin_in = 16'd1234;
    blank_zeros = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    done_at[0] = 0; done_at[1] = 0;
    done_val[0] = '0; done_val[1] = '0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 5) begin bin_in = 16'd5678; start = 1'b1; end
      if (k == 6) start = 1'b0;
      if (done) begin
        if (dones < 2) begin done_at[dones] = k; done_val[dones] = dd_now(); end
        dones++;
      end
    end
    check("chg_done_count", 40'(dones), 40'd2);
    check("chg_first_at", 40'(done_at[0]), 40'd17);
    check("chg_first_val", done_val[0], "01234");
    check("chg_second_at", 40'(done_at[1]), 40'd35);
    check("chg_second_val", done_val[1], "05678");

    // T6: reset mid-conversion
    @(negedge clk);
    bin_in = 16'd9999;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("abort_bytes", dd_now(), "00000");
    check("abort_busy", 40'(busy), 40'd0);
    bin_in = 16'd0;
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) bad = 1;
    end
    check("abort_no_done", 40'(bad), 40'd0);
    check("abort_hold", dd_now(), "00000");

    // T7: randomized against the model
    for (int r = 0; r < 2000; r++) begin
      logic [15:0] v;
      logic b;
      v = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) v = 16'($urandom_range(0, 999));
      b = 1'($urandom_range(0, 1));
      run_conv(v, b, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
